// File: rtl/base_vlat_sr_ev.sv
// Sticky event/status register vector with hardware set/rst, software write and
// write-1-to-clear access, per-bit overrun flags, an overrun-cycle counter and a masked interrupt.
module base_vlat_sr_ev #(
    parameter int               width     = 8,
    parameter logic [0:width-1] rstv      = '0,
    parameter bit               set_pri   = 1'b1,
    parameter int               cnt_width = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [0:width-1]     set,
    input  logic [0:width-1]     rst,
    input  logic                 wr_en,
    input  logic [0:width-1]     wr_data,
    input  logic                 clr_en,
    input  logic [0:width-1]     clr_mask,
    input  logic                 cnt_clr,
    input  logic [0:width-1]     mask,
    output logic [0:width-1]     q,
    output logic [0:width-1]     ovr,
    output logic [cnt_width-1:0] ovr_cnt,
    output logic                 irq,
    output logic                 irq_pulse
);

    localparam logic [cnt_width-1:0] cnt_max = '1;

    logic [0:width-1]     hs;
    logic [0:width-1]     hr;
    logic [0:width-1]     ov_ev;
    logic [0:width-1]     q_sw;
    logic [0:width-1]     ovr_clr;
    logic [0:width-1]     q_next;
    logic [0:width-1]     ovr_next;
    logic [cnt_width-1:0] cnt_next;
    logic                 irq_d;

    // Software access resolves first; hs/hr are mutually exclusive and then override it bit by bit.
    always_comb begin
        hs       = set & (~rst | {width{set_pri}});
        hr       = rst & (~set | {width{~set_pri}});
        ov_ev    = hs & q;
        q_sw     = q;
        ovr_clr  = '0;
        cnt_next = ovr_cnt;

        if (wr_en) begin
            q_sw    = wr_data;
            ovr_clr = '1;
        end else if (clr_en) begin
            q_sw    = q & ~clr_mask;
            ovr_clr = clr_mask;
        end

        q_next   = (q_sw | hs) & ~hr;
        ovr_next = ov_ev | (ovr & ~ovr_clr);

        if (cnt_clr) begin
            cnt_next = '0;
        end else if ((|ov_ev) && (ovr_cnt != cnt_max)) begin
            cnt_next = ovr_cnt + cnt_width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= rstv;
            ovr     <= '0;
            ovr_cnt <= '0;
            irq_d   <= 1'b0;
        end else begin
            q       <= q_next;
            ovr     <= ovr_next;
            ovr_cnt <= cnt_next;
            irq_d   <= irq;
        end
    end

    assign irq       = |(q & mask);
    assign irq_pulse = irq & ~irq_d & ~reset;

endmodule

// File: tb/tb_base_vlat_sr_ev.sv
// Scoreboard bench: two instances (set-wins and rst-wins) share one directed vector table.
module tb_base_vlat_sr_ev;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [0:7] set = '0;
    logic [0:7] rst = '0;
    logic       wr_en = 1'b0;
    logic [0:7] wr_data = '0;
    logic       clr_en = 1'b0;
    logic [0:7] clr_mask = '0;
    logic       cnt_clr = 1'b0;
    logic [0:7] mask = '0;

    logic [0:7] q1, ovr1, q0, ovr0;
    logic [1:0] cnt1;
    logic [3:0] cnt0;
    logic       irq1, pulse1, irq0, pulse0;

    typedef struct {
        int         row;
        logic       chk;
        logic [0:7] q1;
        logic [0:7] ovr1;
        logic [1:0] cnt1;
        logic       irq1;
        logic       pulse1;
        logic [0:7] q0;
        logic [0:7] ovr0;
        logic [3:0] cnt0;
        logic       irq0;
        logic       pulse0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    base_vlat_sr_ev #(.width(8), .rstv(8'hA0), .set_pri(1'b1), .cnt_width(2)) dut (
        .clk(clk), .reset(reset), .set(set), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .clr_en(clr_en), .clr_mask(clr_mask), .cnt_clr(cnt_clr), .mask(mask),
        .q(q1), .ovr(ovr1), .ovr_cnt(cnt1), .irq(irq1), .irq_pulse(pulse1)
    );

    base_vlat_sr_ev #(.width(8), .rstv(8'h00), .set_pri(1'b0), .cnt_width(4)) dut0 (
        .clk(clk), .reset(reset), .set(set), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .clr_en(clr_en), .clr_mask(clr_mask), .cnt_clr(cnt_clr), .mask(mask),
        .q(q0), .ovr(ovr0), .ovr_cnt(cnt0), .irq(irq0), .irq_pulse(pulse0)
    );

    task automatic checkOutput(input int row, input string name, input logic [7:0] act,
                               input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL row%0d %s: actual=%0h required=%0h", row, name, act, req);
        end
    endtask

    // Inputs go on just after a rising edge; the expectation describes what the outputs
    // show during that cycle (registered state from the previous vector, live combinational terms).
    task automatic applyStimulus(
        input int row, input logic r, input logic [0:7] s, input logic [0:7] rs,
        input logic we, input logic [0:7] wd, input logic ce, input logic [0:7] cm,
        input logic cc, input logic [0:7] m, input logic chk,
        input logic [0:7] e_q1, input logic [0:7] e_ovr1, input logic [1:0] e_cnt1,
        input logic e_irq1, input logic e_pulse1,
        input logic [0:7] e_q0, input logic [0:7] e_ovr0, input logic [3:0] e_cnt0,
        input logic e_irq0, input logic e_pulse0);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = r;
        set      = s;
        rst      = rs;
        wr_en    = we;
        wr_data  = wd;
        clr_en   = ce;
        clr_mask = cm;
        cnt_clr  = cc;
        mask     = m;
        e.row = row;    e.chk = chk;
        e.q1 = e_q1;    e.ovr1 = e_ovr1; e.cnt1 = e_cnt1; e.irq1 = e_irq1; e.pulse1 = e_pulse1;
        e.q0 = e_q0;    e.ovr0 = e_ovr0; e.cnt0 = e_cnt0; e.irq0 = e_irq0; e.pulse0 = e_pulse0;
        sb.push_back(e);
    endtask

    // Monitor: every falling edge the DUTs present a full output set; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    checkOutput(e.row, "q_setpri", q1, e.q1);
                    checkOutput(e.row, "ovr_setpri", ovr1, e.ovr1);
                    checkOutput(e.row, "cnt_setpri", 8'(cnt1), 8'(e.cnt1));
                    checkOutput(e.row, "irq_setpri", 8'(irq1), 8'(e.irq1));
                    checkOutput(e.row, "pulse_setpri", 8'(pulse1), 8'(e.pulse1));
                    checkOutput(e.row, "q_rstpri", q0, e.q0);
                    checkOutput(e.row, "ovr_rstpri", ovr0, e.ovr0);
                    checkOutput(e.row, "cnt_rstpri", 8'(cnt0), 8'(e.cnt0));
                    checkOutput(e.row, "irq_rstpri", 8'(irq0), 8'(e.irq0));
                    checkOutput(e.row, "pulse_rstpri", 8'(pulse0), 8'(e.pulse0));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        //             row rst set    rst    we wdata  ce cmask  cc mask   chk q1     ovr1   c1    i p   q0     ovr0   c0    i p
        applyStimulus(0,  1, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h80, 0, 8'h00, 8'h00, 2'd0, 0, 0, 8'h00, 8'h00, 4'd0, 0, 0);
        applyStimulus(1,  1, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h80, 1, 8'hA0, 8'h00, 2'd0, 1, 0, 8'h00, 8'h00, 4'd0, 0, 0);
        applyStimulus(2,  0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h80, 1, 8'hA0, 8'h00, 2'd0, 1, 1, 8'h00, 8'h00, 4'd0, 0, 0);
        applyStimulus(3,  0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 0, 8'h80, 1, 8'hA0, 8'h00, 2'd0, 1, 0, 8'h00, 8'h00, 4'd0, 0, 0);
        applyStimulus(4,  0, 8'h01, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'h00, 8'h00, 2'd0, 0, 0, 8'h00, 8'h00, 4'd0, 0, 0);
        applyStimulus(5,  0, 8'h01, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'h01, 8'h00, 2'd0, 1, 1, 8'h01, 8'h00, 4'd0, 1, 1);
        applyStimulus(6,  0, 8'h03, 8'h03, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'h01, 8'h01, 2'd1, 1, 0, 8'h01, 8'h01, 4'd1, 1, 0);
        applyStimulus(7,  0, 8'h03, 8'h03, 1, 8'hFF, 0, 8'h00, 0, 8'h01, 1, 8'h03, 8'h01, 2'd2, 1, 0, 8'h00, 8'h01, 4'd1, 0, 0);
        applyStimulus(8,  0, 8'h01, 8'h00, 0, 8'h00, 1, 8'h0F, 0, 8'h01, 1, 8'hFF, 8'h03, 2'd3, 1, 0, 8'hFC, 8'h00, 4'd1, 0, 0);
        applyStimulus(9,  0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h01, 1, 8'hF1, 8'h01, 2'd3, 1, 0, 8'hF1, 8'h00, 4'd1, 1, 1);
        applyStimulus(10, 0, 8'h03, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'hF1, 8'h01, 2'd0, 1, 0, 8'hF1, 8'h00, 4'd0, 1, 0);
        applyStimulus(11, 0, 8'h02, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'hF3, 8'h01, 2'd1, 1, 0, 8'hF3, 8'h01, 4'd1, 1, 0);
        applyStimulus(12, 0, 8'h03, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'hF3, 8'h03, 2'd2, 1, 0, 8'hF3, 8'h03, 4'd2, 1, 0);
        applyStimulus(13, 0, 8'h01, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'hF3, 8'h03, 2'd3, 1, 0, 8'hF3, 8'h03, 4'd3, 1, 0);
        applyStimulus(14, 0, 8'h01, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'hF3, 8'h03, 2'd3, 1, 0, 8'hF3, 8'h03, 4'd4, 1, 0);
        applyStimulus(15, 0, 8'h01, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h01, 1, 8'hF3, 8'h03, 2'd3, 1, 0, 8'hF3, 8'h03, 4'd5, 1, 0);
        applyStimulus(16, 0, 8'h00, 8'h00, 1, 8'h55, 1, 8'hFF, 0, 8'h01, 1, 8'hF3, 8'h03, 2'd0, 1, 0, 8'hF3, 8'h03, 4'd0, 1, 0);
        applyStimulus(17, 0, 8'h0C, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'h55, 8'h00, 2'd0, 1, 0, 8'h55, 8'h00, 4'd0, 1, 0);
        applyStimulus(18, 1, 8'hFF, 8'h00, 1, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'h5D, 8'h04, 2'd1, 1, 0, 8'h5D, 8'h04, 4'd1, 1, 0);
        applyStimulus(19, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h01, 1, 8'hA0, 8'h00, 2'd0, 0, 0, 8'h00, 8'h00, 4'd0, 0, 0);
        applyStimulus(20, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h20, 1, 8'hA0, 8'h00, 2'd0, 1, 1, 8'h00, 8'h00, 4'd0, 0, 0);
        applyStimulus(21, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h20, 1, 8'hA0, 8'h00, 2'd0, 1, 0, 8'h00, 8'h00, 4'd0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: actual=%0d pending required=0 pending", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
